// File: rtl/truth_table_checker.sv
// truth_table_checker
// Self-running exhaustive-vector checker for small combinational lab blocks.
// Steps through every input combination in ascending order, holds each one
// for HOLD_CYCLES clocks, samples the DUT's true/complement outputs on the
// last cycle of the hold and records an error count, the first failing
// vector and a sticky complement-error flag.
module truth_table_checker #(
   parameter int                      N_IN        = 3,
   parameter int                      HOLD_CYCLES = 50,
   parameter logic [(1<<N_IN)-1:0]    EXPECTED    = 8'b1110_1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic [N_IN-1:0]   vec,
   input  logic              f_in,
   input  logic              fn_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [N_IN:0]     err_count,
   output logic              first_fail_valid,
   output logic [N_IN-1:0]   first_fail_vec,
   output logic              comp_err
);

   // The hold counter only needs to reach HOLD_CYCLES-1; HOLD_CYCLES >= 2
   // keeps this width at least one bit.
   localparam int HW = $clog2(HOLD_CYCLES);
   localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0]   HOLD_ONE  = HW'(1);
   localparam logic [N_IN-1:0] VEC_MAX   = {N_IN{1'b1}};
   localparam logic [N_IN-1:0] VEC_ONE   = N_IN'(1);
   localparam logic [N_IN:0]   ERR_ONE   = (N_IN+1)'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      APPLY = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state_q;
   logic [N_IN-1:0]    vec_q;
   logic [HW-1:0]      holdCnt_q;
   logic               busy_q;
   logic               done_q;
   logic               pass_q;
   logic [N_IN:0]      errCount_q;
   logic               ffValid_q;
   logic [N_IN-1:0]    ffVec_q;
   logic               compErr_q;

   logic               compFail_d;
   logic               vecFail_d;
   logic [N_IN:0]      errCount_d;

   // Judge the current sample: wrong F, or a complement output that does not
   // actually complement F; also the error count this sample would produce.
   always_comb begin
      compFail_d = (fn_in == f_in);
      vecFail_d  = (f_in != EXPECTED[vec_q]) || compFail_d;
      errCount_d = vecFail_d ? (errCount_q + ERR_ONE) : errCount_q;
   end

   // Run controller: start/restart, hold timing, sampling and result capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         vec_q      <= '0;
         holdCnt_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         errCount_q <= '0;
         ffValid_q  <= 1'b0;
         ffVec_q    <= '0;
         compErr_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q    <= APPLY;
                  vec_q      <= '0;
                  holdCnt_q  <= '0;
                  busy_q     <= 1'b1;
                  done_q     <= 1'b0;
                  pass_q     <= 1'b0;
                  errCount_q <= '0;
                  ffValid_q  <= 1'b0;
                  ffVec_q    <= '0;
                  compErr_q  <= 1'b0;
               end
            end

            APPLY: begin
               if (holdCnt_q == HOLD_LAST) begin
                  holdCnt_q  <= '0;
                  errCount_q <= errCount_d;
                  if (vecFail_d && !ffValid_q) begin
                     ffValid_q <= 1'b1;
                     ffVec_q   <= vec_q;
                  end
                  if (compFail_d) begin
                     compErr_q <= 1'b1;
                  end
                  if (vec_q == VEC_MAX) begin
                     state_q <= DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     pass_q  <= (errCount_d == '0);
                  end else begin
                     vec_q <= vec_q + VEC_ONE;
                  end
               end else begin
                  holdCnt_q <= holdCnt_q + HOLD_ONE;
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               pass_q  <= 1'b0;
            end
         endcase
      end
   end

   assign vec              = vec_q;
   assign busy             = busy_q;
   assign done             = done_q;
   assign pass             = pass_q;
   assign err_count        = errCount_q;
   assign first_fail_valid = ffValid_q;
   assign first_fail_vec   = ffVec_q;
   assign comp_err         = compErr_q;

endmodule

// File: doc/truth_table_checker.md
Name: truth_table_checker

Overview:
- Self-running hardware checker for the 3-input combinational lab blocks; it is the capture and compare end of the exhaustive-vector stimulus flow.
- Drives every input combination to a DUT in ascending order and holds each one for a fixed number of cycles.
- Samples the DUT's true and complement outputs against a parameterised expected truth table.
- Reports pass/fail, an error count and the first failing vector. Sits beside the DUT on the lab FPGA, so no simulator is needed.

Parameters:
- N_IN, 3, number of DUT inputs; 2^N_IN vectors are applied.
- HOLD_CYCLES, 50, clock cycles each vector is held (must be >= 2).
- EXPECTED, 8'b1110_1000, expected F per vector: bit i = F for vec == i (default is 3-input majority); width 2^N_IN.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a run; sampled in IDLE or DONE only.
- vec  output  N_IN  stimulus to the DUT; {x,y,z} = vec[2:0], MSB = x.
- f_in  input  1  DUT true output F.
- fn_in  input  1  DUT complement output Fn.
- busy  output  1  high while vectors are being applied.
- done  output  1  high from run completion until the next start or rst.
- pass  output  1  done && err_count == 0.
- err_count  output  N_IN+1  number of failing vectors (max 2^N_IN, no saturation needed).
- first_fail_valid  output  1  at least one vector failed this run.
- first_fail_vec  output  N_IN  vec value of the first failure; valid only when first_fail_valid is high.
- comp_err  output  1  sticky; some vector had fn_in == f_in.

Behaviour:
- Reset (rst high at an edge, from any state, including mid-run):
  - state=IDLE, vec=0, hold_cnt=0.
  - busy=0, done=0, pass=0, err_count=0.
  - first_fail_valid=0, first_fail_vec=0, comp_err=0.
- FSM states: IDLE, APPLY, DONE.
- IDLE:
  - On start=1: go to APPLY.
  - Clear vec, hold_cnt, err_count, first_fail_* and comp_err.
  - busy=1 from that edge.
- APPLY:
  - vec is held stable; hold_cnt increments each edge.
  - At the edge where hold_cnt == HOLD_CYCLES-1, sample f_in/fn_in.
  - Sampling point is the last cycle of the hold, so DUT propagation has settled.
- Vector fails if f_in != EXPECTED[vec] OR fn_in != ~f_in.
- On a failing sample:
  - err_count += 1.
  - If first_fail_valid == 0: latch first_fail_vec = vec and set first_fail_valid.
  - If fn_in == f_in: also set comp_err.
- After each sample, hold_cnt = 0.
  - vec == 2^N_IN-1: go to DONE on the same edge; busy=0, done=1, vec stays at its max value.
  - Otherwise: vec = vec+1.
- Latency: done rises on exactly the (2^N_IN * HOLD_CYCLES)-th rising edge after the edge that sampled start.
- DONE:
  - done, pass and the result registers hold.
  - start=1 restarts the run exactly as from IDLE: done drops and results clear on that edge.
- start while in APPLY is ignored; the run is not restarted.
- rst and start high together: rst wins.
- Outputs are registered; vec changes only at hold boundaries; no combinational path from f_in/fn_in to any output.

Test Plan:
- HOLD_CYCLES=4, correct majority DUT model, start pulsed 1 cycle:
  - vec steps 0..7, each held 4 cycles.
  - done=1 on the 32nd edge after start; pass=1, err_count=0, comp_err=0, first_fail_valid=0.
- Model with F wrong at vec=3 and vec=6:
  - err_count=2, first_fail_vec=3, first_fail_valid=1, pass=0, comp_err=0.
- Model with fn_in tied equal to f_in but F correct:
  - err_count=8, comp_err=1, first_fail_vec=0, pass=0.
- rst asserted for 1 cycle while vec=5:
  - next edge: vec=0, busy=0, done=0, err_count=0, state IDLE.
  - No further vec change until start.
- start re-pulsed at vec=2 mid-run:
  - Ignored; run completes normally at edge 32.
- Second start in DONE after a failing run, with the model corrected:
  - Results cleared on the start edge; new run ends with pass=1, err_count=0.
